// File: rtl/imm_gen.sv
// imm_gen: registered RISC-V immediate generator for the decode stage.
// A combinational extractor builds the 32-bit immediate for the selected
// instruction format; the result is captured into a register aligned with
// the ID/EX boundary. en=0 stalls the register and holds the last value.
// rst_n clears the output asynchronously.
module imm_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] imm_in,
  input  logic [2:0]  imm_sel,
  output logic [31:0] imm_out
);

  // Format select encoding supplied by the control unit.
  localparam logic [2:0] SEL_I     = 3'b000;
  localparam logic [2:0] SEL_S     = 3'b001;
  localparam logic [2:0] SEL_B     = 3'b010;
  localparam logic [2:0] SEL_U     = 3'b011;
  localparam logic [2:0] SEL_J     = 3'b100;
  localparam logic [2:0] SEL_SHAMT = 3'b101;
  localparam logic [2:0] SEL_ZIMM  = 3'b110;

  // Every signed format takes its upper fill from instr[31] only.
  logic        w_sign;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm_shamt;
  logic [31:0] w_imm_zimm;
  logic [31:0] w_next_imm;
  logic [31:0] r_imm;

  // The opcode field never carries immediate bits; opcode decode lives in
  // the control unit, which drives imm_sel.
  logic        w_unused_opcode;
  assign w_unused_opcode = &{1'b0, imm_in[6:0]};

  assign w_sign = imm_in[31];

  // I-type: loads, ALU immediates, JALR.
  assign w_imm_i = {{20{w_sign}}, imm_in[31:20]};

  // S-type: stores, immediate split around rs2/rs1.
  assign w_imm_s = {{20{w_sign}}, imm_in[31:25], imm_in[11:7]};

  // B-type: branch offset in halfwords, bit 0 always zero.
  assign w_imm_b = {{19{w_sign}}, imm_in[31], imm_in[7], imm_in[30:25],
                    imm_in[11:8], 1'b0};

  // U-type: LUI/AUIPC upper immediate, low 12 bits zero.
  assign w_imm_u = {imm_in[31:12], 12'h000};

  // J-type: JAL offset in halfwords, bit 0 always zero.
  assign w_imm_j = {{11{w_sign}}, imm_in[31], imm_in[19:12], imm_in[20],
                    imm_in[30:21], 1'b0};

  // Shift amount for SLLI/SRLI/SRAI, zero-extended.
  assign w_imm_shamt = {27'd0, imm_in[24:20]};

  // CSR zimm lives in the rs1 field, zero-extended.
  assign w_imm_zimm = {27'd0, imm_in[19:15]};

  // Select the immediate for the requested format; the reserved code gives zero.
  always_comb begin
    w_next_imm = 32'h0000_0000;
    case (imm_sel)
      SEL_I:     w_next_imm = w_imm_i;
      SEL_S:     w_next_imm = w_imm_s;
      SEL_B:     w_next_imm = w_imm_b;
      SEL_U:     w_next_imm = w_imm_u;
      SEL_J:     w_next_imm = w_imm_j;
      SEL_SHAMT: w_next_imm = w_imm_shamt;
      SEL_ZIMM:  w_next_imm = w_imm_zimm;
      default:   w_next_imm = 32'h0000_0000;
    endcase
  end

  // Output register: clear on reset, load when enabled, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_imm <= 32'h0000_0000;
    end else if (en) begin
      r_imm <= w_next_imm;
    end
  end

  assign imm_out = r_imm;

endmodule

// File: tb/tb_imm_gen.sv
// tb_imm_gen: scoreboard bench for imm_gen. The driver pushes the expected
// register contents after every edge; a monitor pops and compares on the
// following falling edge. Expected values come from an arithmetic model of
// the immediate formats plus directed constants.
module tb_imm_gen;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] imm_in;
  logic [2:0]  imm_sel;
  logic [31:0] imm_out;

  logic [31:0] exp_q[$];
  logic [31:0] model_imm;
  int          n_vec;
  int          n_err;

  imm_gen dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .imm_in  (imm_in),
    .imm_sel (imm_sel),
    .imm_out (imm_out)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Immediates built from masks and shifts of the instruction word.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel);
    logic [31:0] fill;
    fill = ins[31] ? 32'hFFFF_FFFF : 32'h0000_0000;
    case (sel)
      3'd0: return (fill & 32'hFFFF_F800) | ((ins >> 20) & 32'h0000_07FF);
      3'd1: return (fill & 32'hFFFF_F800) | ((ins >> 20) & 32'h0000_07E0)
                 | ((ins >> 7) & 32'h0000_001F);
      3'd2: return (fill & 32'hFFFF_F000) | (((ins >> 7) & 32'h1) << 11)
                 | ((ins >> 20) & 32'h0000_07E0) | ((ins >> 7) & 32'h0000_001E);
      3'd3: return ins & 32'hFFFF_F000;
      3'd4: return (fill & 32'hFFF0_0000) | (ins & 32'h000F_F000)
                 | (((ins >> 20) & 32'h1) << 11) | ((ins >> 20) & 32'h0000_07FE);
      3'd5: return (ins >> 20) & 32'h0000_001F;
      3'd6: return (ins >> 15) & 32'h0000_001F;
      default: return 32'h0000_0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Apply one cycle of inputs; afterwards push what the register must hold.
  task automatic drive(input logic [31:0] ins, input logic [2:0] sel, input logic e);
    @(negedge clk);
    imm_in  = ins;
    imm_sel = sel;
    en      = e;
    @(posedge clk);
    #1;
    if (e) model_imm = ref_imm(ins, sel);
    exp_q.push_back(model_imm);
  endtask

  // Same as drive, but the expectation is a fixed constant.
  task automatic drive_exp(input logic [31:0] ins, input logic [2:0] sel, input logic [31:0] exp);
    @(negedge clk);
    imm_in  = ins;
    imm_sel = sel;
    en      = 1'b1;
    @(posedge clk);
    #1;
    model_imm = exp;
    exp_q.push_back(exp);
  endtask

  task automatic drain;
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic release_reset;
    @(negedge clk);
    rst_n     = 1'b1;
    model_imm = 32'h0000_0000;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("scoreboard", imm_out, e);
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] sweep_exp[8];
  logic [31:0] sign_exp[6];

  initial begin
    n_vec     = 0;
    n_err     = 0;
    model_imm = 32'h0;
    rst_n     = 1'b0;
    en        = 1'b1;
    imm_in    = 32'h0;
    imm_sel   = 3'd0;

    // Reset held with random inputs across toggling clock.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      imm_in  = $urandom;
      imm_sel = 3'($urandom_range(0, 7));
      en      = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("reset_hold", imm_out, 32'h0);
    end
    release_reset();

    // Format sweep on one instruction word; instr[19:15] of it is all zero.
    sweep_exp = '{32'h0000_0011, 32'h0000_0000, 32'h0000_0000, 32'h0110_1000,
                  32'h0000_1810, 32'h0000_0011, 32'h0000_0000, 32'h0000_0000};
    for (int s = 0; s < 8; s++) drive_exp(32'h0110_1010, 3'(s), sweep_exp[s]);

    // Sign extension from instr[31] alone.
    sign_exp = '{32'hFFFF_F800, 32'hFFFF_F800, 32'hFFFF_F000, 32'h8000_0000,
                 32'hFFF0_0000, 32'h0000_0000};
    for (int s = 0; s < 6; s++) drive_exp(32'h8000_0000, 3'(s), sign_exp[s]);

    // Fully negative immediates.
    drive_exp(32'hFFF0_0093, 3'd0, 32'hFFFF_FFFF);
    drive_exp(32'hFE00_0EE3, 3'd2, 32'hFFFF_FFFC);

    // Stall: hold 0x11 while inputs churn, then resume.
    drive_exp(32'h0110_1010, 3'd0, 32'h0000_0011);
    for (int i = 0; i < 3; i++) drive($urandom, 3'($urandom_range(0, 7)), 1'b0);
    drive(32'hFFF0_0093, 3'd0, 1'b1);
    drain();

    // Asynchronous reset between edges while output is nonzero.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", imm_out, 32'h0);
    @(negedge clk);
    en     = 1'b1;
    imm_in = 32'hFFF0_0093;
    @(posedge clk);
    #1;
    check("reset_low_en", imm_out, 32'h0);
    release_reset();
    drive(32'hFE00_0EE3, 3'd2, 1'b1);

    // Reset during a stall, then stay stalled: output remains zero.
    drive(32'h1234_5678, 3'd3, 1'b0);
    drain();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_mid_stall", imm_out, 32'h0);
    release_reset();
    drive(32'h8765_4321, 3'd4, 1'b0);
    drive(32'h8765_4321, 3'd4, 1'b1);

    // Random stream.
    for (int i = 0; i < 10000; i++) begin
      drive($urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
